rsa_job_sequencer: RTL and testbench



---
 rtl/rsa_job_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: runs one encrypt/decrypt job through an RSA control core.
// Optional per-wait watchdog enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer #(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_mode,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic [WIDTH-1:0]     core_p,
    output logic [WIDTH-1:0]     core_q,
    output logic                 core_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   core_msg_in,
    output logic                 core_reset_inverter,
    output logic                 core_reset_mod_exp,
    input  logic                 core_inverter_finish,
    input  logic                 core_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   core_msg_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_timeout,
    output logic                 busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // The *_RST cycle doubles as the guard: a finish seen on its exit edge is stale.
    typedef enum logic [2:0] {
        IDLE,
        INV_RST,
        INV_WAIT,
        EXP_RST,
        EXP_WAIT,
        RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_fin_rsp;
    logic                 w_tmo_rsp;
    logic                 w_expired;
    logic                 r_rst_inv;
    logic                 r_rst_exp;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic                 r_mode;
    logic [2*WIDTH-1:0]   r_msg;
    logic [2*WIDTH-1:0]   r_rsp_msg;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_expired = (r_state == INV_WAIT || r_state == EXP_WAIT)
                    && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == INV_WAIT || r_state == EXP_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_fin_rsp) begin
            r_timeout <= 1'b0;
        end else if (w_tmo_rsp) begin
            r_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = r_timeout;
`else
    assign w_expired   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && req_valid;

    always_comb begin
        w_next    = r_state;
        w_fin_rsp = 1'b0;
        w_tmo_rsp = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) w_next = INV_RST;
            end
            INV_RST: w_next = INV_WAIT;
            INV_WAIT: begin
                if (core_inverter_finish) begin
                    w_next = EXP_RST;
                end else if (w_expired) begin
                    w_next    = RESP;
                    w_tmo_rsp = 1'b1;
                end
            end
            EXP_RST: w_next = EXP_WAIT;
            EXP_WAIT: begin
                // A finish on the expiry edge still counts as a real result.
                if (core_mod_exp_finish) begin
                    w_next    = RESP;
                    w_fin_rsp = 1'b1;
                end else if (w_expired) begin
                    w_next    = RESP;
                    w_tmo_rsp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rst_inv <= 1'b0;
            r_rst_exp <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rst_inv <= (w_next == INV_RST);
            r_rst_exp <= (w_next == EXP_RST);
        end
    end

    // Core samples operands continuously, so hold them until the next job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p    <= '0;
            r_q    <= '0;
            r_mode <= 1'b0;
            r_msg  <= '0;
        end else if (w_accept) begin
            r_p    <= req_p;
            r_q    <= req_q;
            r_mode <= req_mode;
            r_msg  <= req_msg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_msg <= '0;
        end else if (w_fin_rsp) begin
            r_rsp_msg <= core_msg_out;
        end else if (w_tmo_rsp) begin
            r_rsp_msg <= '0;
        end
    end

    assign req_ready            = (r_state == IDLE);
    assign busy                 = (r_state != IDLE);
    assign rsp_valid            = (r_state == RESP);
    assign rsp_msg              = r_rsp_msg;
    assign core_p               = r_p;
    assign core_q               = r_q;
    assign core_encrypt_decrypt = r_mode;
    assign core_msg_in          = r_msg;
    assign core_reset_inverter  = r_rst_inv;
    assign core_reset_mod_exp   = r_rst_exp;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer: randomized jobs against a latency/result model,
// driving a behavioural stub of the RSA control core.
module tb_rsa_job_sequencer;

    localparam int W   = 128;
    localparam int TMO = 100;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_p;
    logic [W-1:0]     req_q;
    logic             req_mode;
    logic [2*W-1:0]   req_msg;
    logic [W-1:0]     core_p;
    logic [W-1:0]     core_q;
    logic             core_encrypt_decrypt;
    logic [2*W-1:0]   core_msg_in;
    logic             core_reset_inverter;
    logic             core_reset_mod_exp;
    logic             inv_fin;
    logic             exp_fin;
    logic [2*W-1:0]   stub_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_msg;
    logic             rsp_timeout;
    logic             busy;

    int               n_cmp;
    int               n_bad;

    // stub knobs: finish delay after the strobe (0 = same edge, <0 = never)
    int               stub_d1;
    int               stub_d2;
    logic [2*W-1:0]   stub_res;
    int               inv_left;
    int               exp_left;

    rsa_job_sequencer #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_p                (req_p),
        .req_q                (req_q),
        .req_mode             (req_mode),
        .req_msg              (req_msg),
        .core_p               (core_p),
        .core_q               (core_q),
        .core_encrypt_decrypt (core_encrypt_decrypt),
        .core_msg_in          (core_msg_in),
        .core_reset_inverter  (core_reset_inverter),
        .core_reset_mod_exp   (core_reset_mod_exp),
        .core_inverter_finish (inv_fin),
        .core_mod_exp_finish  (exp_fin),
        .core_msg_out         (stub_out),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_msg              (rsp_msg),
        .rsp_timeout          (rsp_timeout),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: finish flags stay high until the next strobe (stale finish).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_fin  <= 1'b0;
            exp_fin  <= 1'b0;
            inv_left <= 0;
            exp_left <= 0;
            stub_out <= '0;
        end else begin
            if (core_reset_inverter) begin
                inv_fin  <= (stub_d1 == 0);
                inv_left <= stub_d1;
            end else if (inv_left > 0) begin
                inv_left <= inv_left - 1;
                if (inv_left == 1) inv_fin <= 1'b1;
            end
            if (core_reset_mod_exp) begin
                exp_fin  <= (stub_d2 == 0);
                exp_left <= stub_d2;
                if (stub_d2 == 0) stub_out <= stub_res;
            end else if (exp_left > 0) begin
                exp_left <= exp_left - 1;
                if (exp_left == 1) begin
                    exp_fin  <= 1'b1;
                    stub_out <= stub_res;
                end
            end
        end
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [2*W-1:0] rand_2w();
        return {rand_w(), rand_w()};
    endfunction

    // Model: finish set d cycles after the strobe is seen by the core
    // is taken d+2 edges after the strobe edge; response 2+d2 after that.
    task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q,
                           input logic m, input logic [2*W-1:0] msg,
                           input int d1, input int d2,
                           input logic [2*W-1:0] res, input int hold,
                           input bit tmo, input string tag);
        int             f1;
        int             lat;
        logic [4:0]     got;
        logic [4:0]     exp;
        logic [2*W-1:0] held;
        stub_d1   = d1;
        stub_d2   = d2;
        stub_res  = res;
        req_p     = p;
        req_q     = q;
        req_mode  = m;
        req_msg   = msg;
        req_valid = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept_ready got=%b want=1", tag, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_p     = rand_w();
        f1        = 2 + d1;
        lat       = tmo ? f1 + TMO + 1 : f1 + 2 + d2;
        for (int t = 0; t <= lat; t++) begin
            if (t > 0) @(negedge clk);
            exp = {t == 0, t == f1, t == lat, 1'b1, 1'b0};
            got = {core_reset_inverter, core_reset_mod_exp, rsp_valid,
                   busy, req_ready};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s seq t=%0d inv,exp,vld,busy,rdy got=%b want=%b",
                         tag, t, got, exp);
                break;
            end
        end
        n_cmp++;
        if ({core_p, core_q, core_encrypt_decrypt, core_msg_in} !== {p, q, m, msg}) begin
            n_bad++;
            $display("FAIL %s operands got p=%h mode=%b msg=%h want p=%h mode=%b msg=%h",
                     tag, core_p, core_encrypt_decrypt, core_msg_in, p, m, msg);
        end
        held = tmo ? '0 : res;
        n_cmp++;
        if ({rsp_timeout, rsp_msg} !== {tmo, held}) begin
            n_bad++;
            $display("FAIL %s result got tmo=%b msg=%h want tmo=%b msg=%h",
                     tag, rsp_timeout, rsp_msg, tmo, held);
        end
        if (hold > 0) begin
            req_valid = 1'b1;
            req_q     = rand_w();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, req_ready, busy, core_reset_inverter, rsp_timeout,
                 rsp_msg, core_p} !== {4'b1010, tmo, held, p}) begin
                n_bad++;
                $display("FAIL %s hold h=%0d vld=%b rdy=%b busy=%b msg=%h p=%h",
                         tag, h, rsp_valid, req_ready, busy, rsp_msg, core_p);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready, busy, core_reset_inverter, core_p} !==
            {4'b0100, p}) begin
            n_bad++;
            $display("FAIL %s after_H vld=%b rdy=%b busy=%b inv=%b p=%h",
                     tag, rsp_valid, req_ready, busy, core_reset_inverter, core_p);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({core_p, core_q, core_encrypt_decrypt, core_msg_in, core_reset_inverter,
             core_reset_mod_exp, rsp_valid, rsp_msg, rsp_timeout, busy} !== '0
            || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state rdy=%b busy=%b vld=%b inv=%b exp=%b p=%h",
                     req_ready, busy, rsp_valid, core_reset_inverter,
                     core_reset_mod_exp, core_p);
        end
    endtask

    task automatic test_single_job();
        run_job(128'd113680897410347, 128'd7999808077935876437321, 1'b0,
                256'h7b2800000000, 20, 40, 256'h1234, 0, 1'b0, "single");
    endtask

    task automatic test_back_pressure();
        run_job(rand_w(), rand_w(), 1'b1, rand_2w(), 3, 5, rand_2w(), 10,
                1'b0, "backpressure");
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 2, 2, rand_2w(), 0,
                1'b0, "after_bp");
    endtask

    task automatic test_back_to_back();
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 0, 0, rand_2w(), 0,
                1'b0, "min_latency");
        run_job(rand_w(), rand_w(), 1'b1, rand_2w(), 0, 0, rand_2w(), 0,
                1'b0, "b2b");
    endtask

    task automatic test_stale_finish();
        run_job(rand_w(), rand_w(), 1'b1, rand_2w(), 1, 1, rand_2w(), 0,
                1'b0, "stale");
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 4, 1, rand_2w(), 1,
                1'b0, "stale2");
    endtask

    task automatic test_random_jobs();
        for (int i = 0; i < 8; i++) begin
            run_job(rand_w(), rand_w(), 1'($urandom_range(0, 1)), rand_2w(),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    rand_2w(), int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    task automatic test_timeout();
`ifdef RSA_SEQ_TIMEOUT_EN
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 2, -1, rand_2w(), 2,
                1'b1, "timeout");
        run_job(rand_w(), rand_w(), 1'b1, rand_2w(), 1, TMO - 1, rand_2w(), 0,
                1'b0, "finish_wins");
`else
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 2, TMO + 20, rand_2w(), 0,
                1'b0, "no_watchdog");
`endif
    endtask

    task automatic test_reset_mid_job();
        stub_d1   = 2;
        stub_d2   = 30;
        stub_res  = rand_2w();
        req_p     = rand_w();
        req_q     = rand_w();
        req_mode  = 1'b1;
        req_msg   = rand_2w();
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++;
        if ({busy, rsp_valid, core_p} !== {2'b10, req_p}) begin
            n_bad++;
            $display("FAIL mid_job_pre busy=%b vld=%b p=%h", busy, rsp_valid, core_p);
        end
        reset = 1'b1;
        #1;
        test_reset();
        @(posedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        run_job(rand_w(), rand_w(), 1'b0, rand_2w(), 3, 4, rand_2w(), 1,
                1'b0, "post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_p     = '0;
        req_q     = '0;
        req_mode  = 1'b0;
        req_msg   = '0;
        rsp_ready = 1'b0;
        stub_d1   = 1;
        stub_d2   = 1;
        stub_res  = '0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_single_job();
        test_back_pressure();
        test_back_to_back();
        test_stale_finish();
        test_random_jobs();
        test_timeout();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
